// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg
//   Shared definitions for the AXI3 SRAM slave: FSM state encoding, AXI
//   response codes, the INCR burst code and the 32-bit beat size code.
//   There are no ports; the slave imports this package.
package axi_sram_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    // Response for a new request: an address outside the memory decodes to
    // DECERR; an unsupported size or burst type is a slave error.
    function automatic logic [1:0] req_resp(input logic       addr_hi_bad,
                                            input logic [2:0] size,
                                            input logic [1:0] burst);
        if (addr_hi_bad)
            return RESP_DECERR;
        else if (size != SIZE_WORD || burst != BURST_INCR)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// sram_1rw
//   Single-port 32-bit SRAM model with per-byte write enables and a
//   registered read port (data valid one cycle after a read enable).
//   Ports:
//     i_clk            clock
//     i_en             access enable
//     i_we[3:0]        byte write enables (all zero = read)
//     i_addr           word address
//     i_wdata[31:0]    write data
//     o_rdata[31:0]    read data, held until the next read
module sram_1rw #(
    parameter int ADDR_BIT = 14
) (
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [3:0]          i_we,
    input  logic [ADDR_BIT-1:0] i_addr,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata
);

    logic [31:0] r_mem [2**ADDR_BIT];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we == 4'b0000) begin
                o_rdata <= r_mem[i_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (i_we[b])
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3 slave that serves one INCR burst at a time from an external
//   single-port 32-bit SRAM (sram_1rw, instantiated by the parent).
//   Ports:
//     i_clk, i_rst         clock, synchronous active-high reset
//     AR/R channel         i_ar*, o_arready, o_r*, i_rready
//     AW/W/B channel       i_aw*, o_awready, i_w*, o_wready, o_b*, i_bready
//     SRAM port            o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
//                          i_mem_rdata (valid one cycle after a read)
//   Build option:
//     AXI_SLAVE_ERR_EN     when defined, out-of-range addresses give DECERR,
//                          unsupported size/burst or a misplaced wlast give
//                          SLVERR; errored bursts neither write nor return data.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_IDLE    | ready for AR or AW (read wins when both are valid)
//   ST_RD_REQ  | issue SRAM read for the current beat
//   ST_RD_DATA | present read beat until rready
//   ST_WR_DATA | accept write beats, one SRAM write each
//   ST_WR_RESP | present write response until bready
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int WRD_ADDR_BIT = 14
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3:0]              i_arid,
    input  logic [31:0]             i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [3:0]              o_rid,
    output logic [31:0]             o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    input  logic [3:0]              i_awid,
    input  logic [31:0]             i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [3:0]              i_wid,
    input  logic [31:0]             i_wdata,
    input  logic [3:0]              i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [3:0]              o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_mem_en,
    output logic [3:0]              o_mem_we,
    output logic [WRD_ADDR_BIT-1:0] o_mem_addr,
    output logic [31:0]             o_mem_wdata,
    input  logic [31:0]             i_mem_rdata
);

    localparam logic [WRD_ADDR_BIT-1:0] ADDR_ONE = WRD_ADDR_BIT'(1);

    state_t                  r_state, w_next;
    logic [3:0]              r_id;
    logic [WRD_ADDR_BIT-1:0] r_addr;
    logic [7:0]              r_len, r_cnt;
    logic [1:0]              r_resp;
    logic [31:0]             r_rdata;
    logic                    r_first;
    logic                    w_last;
    logic [1:0]              w_ar_resp, w_aw_resp, w_beat_resp;
    logic                    w_unused;

    assign w_last = (r_cnt == r_len);

`ifdef AXI_SLAVE_ERR_EN
    assign w_ar_resp = req_resp(i_araddr[31:WRD_ADDR_BIT+2] != '0, i_arsize, i_arburst);
    assign w_aw_resp = req_resp(i_awaddr[31:WRD_ADDR_BIT+2] != '0, i_awsize, i_awburst);
    // A wlast that disagrees with the beat count turns an OKAY burst into
    // SLVERR from that beat on; earlier errors take precedence.
    assign w_beat_resp = (r_resp == RESP_OKAY && i_wlast != w_last) ? RESP_SLVERR : r_resp;
    assign w_unused    = ^{i_araddr[1:0], i_awaddr[1:0], i_wid};
`else
    assign w_ar_resp   = RESP_OKAY;
    assign w_aw_resp   = RESP_OKAY;
    assign w_beat_resp = RESP_OKAY;
    assign w_unused    = ^{i_araddr[31:WRD_ADDR_BIT+2], i_araddr[1:0], i_arsize, i_arburst,
                           i_awaddr[31:WRD_ADDR_BIT+2], i_awaddr[1:0], i_awsize, i_awburst,
                           i_wid, i_wlast};
`endif

    assign o_rid      = r_id;
    assign o_bid      = r_id;
    assign o_mem_addr = r_addr;

    // Outputs are gated by i_rst so nothing is driven during the reset cycle,
    // even while the state register still holds a mid-burst state.
    always_comb begin
        w_next      = r_state;
        o_arready   = 1'b0;
        o_awready   = 1'b0;
        o_rvalid    = 1'b0;
        o_rdata     = '0;
        o_rresp     = RESP_OKAY;
        o_rlast     = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        o_bresp     = RESP_OKAY;
        o_mem_en    = 1'b0;
        o_mem_we    = '0;
        o_mem_wdata = '0;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    o_arready = 1'b1;
                    o_awready = !i_arvalid;
                    if (i_arvalid)
                        w_next = ST_RD_REQ;
                    else if (i_awvalid)
                        w_next = ST_WR_DATA;
                end
                ST_RD_REQ: begin
                    o_mem_en = 1'b1;
                    w_next   = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    o_rvalid = 1'b1;
                    o_rlast  = w_last;
                    o_rresp  = r_resp;
                    // First cycle forwards the SRAM output directly so a beat
                    // can complete every two cycles; later cycles use the copy.
                    if (r_resp == RESP_OKAY)
                        o_rdata = r_first ? i_mem_rdata : r_rdata;
                    if (i_rready)
                        w_next = w_last ? ST_IDLE : ST_RD_REQ;
                end
                ST_WR_DATA: begin
                    o_wready = 1'b1;
                    if (i_wvalid) begin
                        o_mem_en    = 1'b1;
                        o_mem_we    = (w_beat_resp == RESP_OKAY) ? i_wstrb : 4'b0000;
                        o_mem_wdata = i_wdata;
                        if (w_last)
                            w_next = ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    o_bvalid = 1'b1;
                    o_bresp  = r_resp;
                    if (i_bready)
                        w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_resp  <= RESP_OKAY;
            r_rdata <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (i_arvalid) begin
                        r_id   <= i_arid;
                        r_addr <= i_araddr[WRD_ADDR_BIT+1:2];
                        r_len  <= i_arlen;
                        r_cnt  <= '0;
                        r_resp <= w_ar_resp;
                    end else if (i_awvalid) begin
                        r_id   <= i_awid;
                        r_addr <= i_awaddr[WRD_ADDR_BIT+1:2];
                        r_len  <= i_awlen;
                        r_cnt  <= '0;
                        r_resp <= w_aw_resp;
                    end
                end
                ST_RD_REQ: r_first <= 1'b1;
                ST_RD_DATA: begin
                    if (r_first) begin
                        r_rdata <= i_mem_rdata;
                        r_first <= 1'b0;
                    end
                    if (i_rready && !w_last) begin
                        r_addr <= r_addr + ADDR_ONE;
                        r_cnt  <= r_cnt + 8'd1;
                    end
                end
                ST_WR_DATA: begin
                    if (i_wvalid) begin
                        r_addr <= r_addr + ADDR_ONE;
                        r_cnt  <= r_cnt + 8'd1;
                        r_resp <= w_beat_resp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Drives the slave plus an sram_1rw with directed and random bursts and
//   compares every beat against a word-array model of the memory.
module tb_axi_sram_slave;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    arid = '0;
    logic [31:0]   araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = 3'd2;
    logic [1:0]    arburst = 2'd1;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid;
    logic          rready = 1'b0;
    logic [3:0]    awid = '0;
    logic [31:0]   awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = 3'd2;
    logic [1:0]    awburst = 2'd1;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [3:0]    wid = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [3:0]    bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd_q [256];
    logic [3:0]  ws_q [256];
    logic        rd_done = 1'b0;
    logic        chk_order = 1'b0;

    always #5 clk = ~clk;

    axi_sram_slave #(.WRD_ADDR_BIT(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
        .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
        .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast),
        .o_rvalid(rvalid), .i_rready(rready),
        .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
        .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
        .i_wid(wid), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
        .i_wvalid(wvalid), .o_wready(wready),
        .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    sram_1rw #(.ADDR_BIT(AW)) u_mem (
        .i_clk(clk), .i_en(mem_en), .i_we(mem_we), .i_addr(mem_addr),
        .i_wdata(mem_wdata), .o_rdata(mem_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] s,
                                            input logic [1:0] b);
        logic hi, bad;
        hi  = (a >> (AW + 2)) != 32'd0;
        bad = (s != 3'd2) || (b != 2'd1);
`ifdef AXI_SLAVE_ERR_EN
        if (hi)  return 2'b11;
        if (bad) return 2'b10;
        return 2'b00;
`else
        // error checking compiled out: always OKAY
        return (hi && bad && 1'b0) ? 2'b11 : 2'b00;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a, input int i);
        return int'(((a >> 2) + 32'(i)) & 32'(DEPTH - 1));
    endfunction

    task automatic merge(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    // All tasks start and end 1 time unit after a rising edge; outputs are
    // sampled on falling edges.
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] id, input int bstall);
        logic [1:0] er;
        int n;
        er = exp_resp(addr, size, burst);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 300) begin @(negedge clk); n++; end
        check_val("aw_ready", awready, 1);
        if (chk_order) check_val("rd_before_wr", rd_done, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            wdata = wd_q[i]; wstrb = ws_q[i]; wlast = (i == len); wid = 4'($urandom);
            wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wready && n < 50) begin @(negedge clk); n++; end
            check_val("w_ready", wready, 1);
            check_val("w_mem_en", mem_en, 1);
            check_val("w_mem_we", mem_we, (er == 2'b00) ? ws_q[i] : 4'b0000);
            check_val("w_mem_addr", mem_addr, widx(addr, i));
            if (er == 2'b00) merge(widx(addr, i), wd_q[i], ws_q[i]);
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
        end
        bready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check_val("b_valid", bvalid, 1);
        for (int j = 0; j < bstall; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("b_held", bvalid, 1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        check_val("b_valid_hs", bvalid, 1);
        check_val("b_resp", bresp, er);
        check_val("b_id", bid, id);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] id,
                              input int stall_beat, input int stall_len, input bit rnd,
                              input bit chk_cyc);
        logic [1:0] er;
        int n, beat, cyc, stalled;
        er = exp_resp(addr, size, burst);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 300) begin @(negedge clk); n++; end
        check_val("ar_ready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        beat = 0; cyc = 0; stalled = 0;
        rready = rnd ? 1'($urandom_range(0, 1)) : !(beat == stall_beat && stalled < stall_len);
        while (beat <= len && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rvalid) begin
                check_val("r_data", rdata, (er == 2'b00) ? ref_mem[widx(addr, beat)] : 32'd0);
                check_val("r_last", rlast, beat == len);
                check_val("r_resp", rresp, er);
                check_val("r_id", rid, id);
                if (rready) beat++;
                else stalled++;
            end else begin
                check_val("r_data_idle", rdata, 0);
            end
            @(posedge clk); #1;
            rready = rnd ? 1'($urandom_range(0, 1)) : !(beat == stall_beat && stalled < stall_len);
        end
        check_val("r_beats", beat, len + 1);
        if (chk_cyc) check_val("r_cycles", cyc, 2 * (len + 1));
        if (stall_len > 0 && !rnd) check_val("r_stalled", stalled, stall_len);
        rready = 1'b0;
        rd_done = 1'b1;
    endtask

    initial begin
        int a, l;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_outs", {arready, awready, rvalid, wready, bvalid, mem_en, mem_we, rlast},
                  0);
        check_val("rst_data", {rdata, rid, bid, rresp, bresp}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_arready", arready, 1);
        check_val("post_rst_awready", awready, 1);
        @(posedge clk); #1;

        // fill the whole memory so every later read has a known value
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
            write_burst(32'(k * 256), 63, 3'd2, 2'd1, 4'(k), 0);
        end

        // 16-beat read from word 0x10, full throughput
        read_burst(32'h40, 15, 3'd2, 2'd1, 4'd3, -1, 0, 1'b0, 1'b1);

        // write then read back
        for (int i = 0; i < 4; i++) begin wd_q[i] = 32'hA0 + 32'(i); ws_q[i] = 4'hF; end
        write_burst(32'h100, 3, 3'd2, 2'd1, 4'd5, 0);
        read_burst(32'h100, 3, 3'd2, 2'd1, 4'd6, -1, 0, 1'b0, 1'b1);

        // byte strobes
        wd_q[0] = 32'hFFFF_FFFF; ws_q[0] = 4'hF;
        write_burst(32'h200, 0, 3'd2, 2'd1, 4'd1, 0);
        wd_q[0] = 32'h0; ws_q[0] = 4'b0101;
        write_burst(32'h200, 0, 3'd2, 2'd1, 4'd1, 0);
        read_burst(32'h200, 0, 3'd2, 2'd1, 4'd2, -1, 0, 1'b0, 1'b1);

        // backpressure on R and B
        read_burst(32'h0, 7, 3'd2, 2'd1, 4'd7, 3, 5, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
        write_burst(32'h20, 1, 3'd2, 2'd1, 4'd8, 3);

        // burst wrapping across the top of memory
        for (int i = 0; i < 5; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
        write_burst(32'((DEPTH - 2) * 4), 4, 3'd2, 2'd1, 4'd9, 0);
        read_burst(32'((DEPTH - 2) * 4), 4, 3'd2, 2'd1, 4'd9, -1, 0, 1'b0, 1'b1);

        // simultaneous AR and AW: read must finish before AW is accepted
        for (int i = 0; i < 3; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
        rd_done = 1'b0;
        chk_order = 1'b1;
        fork
            read_burst(32'h300, 3, 3'd2, 2'd1, 4'd10, -1, 0, 1'b0, 1'b0);
            write_burst(32'h180, 2, 3'd2, 2'd1, 4'd11, 0);
        join
        chk_order = 1'b0;

        // reset in the middle of an 8-beat write
        awid = 4'd12; awaddr = 32'h280; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wdata = $urandom; wstrb = 4'hF; wvalid = 1'b1;
            merge(widx(32'h280, i), wdata, 4'hF);
            @(posedge clk); #1;
        end
        wdata = $urandom; rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_mem_en", mem_en, 0);
        check_val("mid_rst_mem_we", mem_we, 0);
        check_val("mid_rst_wready", wready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_arready", arready, 1);
        check_val("mid_rst_awready", awready, 1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("mid_rst_no_b", {bvalid, mem_en}, 0);
            @(posedge clk); #1;
        end
        read_burst(32'h280, 7, 3'd2, 2'd1, 4'd13, -1, 0, 1'b0, 1'b1);

`ifdef AXI_SLAVE_ERR_EN
        read_burst(32'hFFFF_0000, 1, 3'd2, 2'd1, 4'd4, -1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
        write_burst(32'h40, 1, 3'd1, 2'd1, 4'd4, 0);
        read_burst(32'h40, 1, 3'd2, 2'd1, 4'd4, -1, 0, 1'b0, 1'b1);
`endif

        // random traffic
        for (int t = 0; t < 24; t++) begin
            a = $urandom_range(0, DEPTH - 1) * 4;
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= l; i++) begin
                    wd_q[i] = $urandom; ws_q[i] = 4'($urandom);
                end
                write_burst(32'(a), l, 3'd2, 2'd1, 4'($urandom), $urandom_range(0, 3));
            end else begin
                read_burst(32'(a), l, 3'd2, 2'd1, 4'($urandom), -1, 0, 1'b1, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
